lc3b_muldiv: RTL

//   Iterative multi-cycle multiply/divide unit beside the single-cycle ALU.

---
 rtl/lc3b_muldiv_if.sv | 25 ++
 rtl/lc3b_muldiv.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lc3b_muldiv_if.sv
// Request/result bundle between the datapath (master) and the multi-cycle
// multiply/divide unit (slave).
interface lc3b_muldiv_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/lc3b_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) unit.
// One iteration per clock, WIDTH iterations per operation; divide by zero short-circuits.
module lc3b_muldiv #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  lc3b_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic               op_q;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   dvsr;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quot_nxt;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    acc_nxt   = acc + (mplier[0] ? mcand : '0);
    rem_shift = {rem, quot[WIDTH-1]};
    rem_nxt   = rem_shift[WIDTH-1:0];
    quot_nxt  = {quot[WIDTH-2:0], 1'b0};
    // Compare at WIDTH+1 bits so the bit shifted out of rem still counts.
    if (rem_shift >= {1'b0, dvsr}) begin
      rem_nxt  = WIDTH'(rem_shift - {1'b0, dvsr});
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= 1'b0;
      count           <= '0;
      acc             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      rem             <= '0;
      quot            <= '0;
      dvsr            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.result_lo   <= '0;
      bus.result_hi   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            rem    <= '0;
            quot   <= bus.a;
            dvsr   <= bus.b;
            if (bus.op && bus.b == '0) begin
              state           <= DONE;
              bus.busy        <= 1'b0;
              bus.done        <= 1'b1;
              bus.result_lo   <= '1;
              bus.result_hi   <= bus.a;
              bus.div_by_zero <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        RUN: begin
          count  <= count + 1'b1;
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nxt;
          quot   <= quot_nxt;
          if (count == LAST) begin
            // Outputs load from the final iteration's values on the edge entering DONE.
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.div_by_zero <= 1'b0;
            if (op_q) begin
              bus.result_lo <= quot_nxt;
              bus.result_hi <= rem_nxt;
            end else begin
              bus.result_lo <= acc_nxt[WIDTH-1:0];
              bus.result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
            end
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule
